dm_cache_ctrl_fsm: RTL and testbench

// Controller for the direct-mapped, write-back, write-allocate cache. Sits between CPU and main memory.

---
 rtl/cache_def_pkg.sv | 85 ++++++++
 rtl/dm_cache_ctrl_fsm.sv | 210 +++++++++++++++++++++
 tb/tb_dm_cache_ctrl_fsm.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_def_pkg.sv
// ----------------------------------------------------------------------------
// cache_def_pkg
// Shared definitions for the direct-mapped, write-back, write-allocate cache
// controller: address field positions, tag/data array entry types, CPU and
// memory request/response records, FSM state encoding, and word helpers.
// ----------------------------------------------------------------------------
package cache_def_pkg;

    localparam int ADDR_W    = 32;
    localparam int WORD_W    = 32;
    localparam int LINE_W    = 128;
    localparam int INDEX_W   = 10;
    localparam int TAG_W     = ADDR_W - INDEX_W - 4;

    // Byte-address field positions: tag | index | word | byte
    localparam int TAG_MSB   = 31;
    localparam int TAG_LSB   = 14;
    localparam int INDEX_MSB = 13;
    localparam int INDEX_LSB = 4;
    localparam int WORD_MSB  = 3;
    localparam int WORD_LSB  = 2;

    // Tag array entry, 20 bits: {valid, dirty, tag}
    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } cache_tag_type;

    // Array port control (shared shape for tag and data arrays)
    typedef struct packed {
        logic [INDEX_W-1:0] index;
        logic               we;
    } cache_req_type;

    typedef logic [LINE_W-1:0] cache_data_type;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
        logic              rw;
        logic              valid;
    } cpu_req_type;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              ready;
    } cpu_result_type;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        cache_data_type    data;
        logic              rw;
        logic              valid;
    } mem_req_type;

    typedef struct packed {
        cache_data_type data;
        logic           ready;
    } mem_data_type;

    // Controller state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE        = 2'd0;
    localparam state_t ST_COMPARE_TAG = 2'd1;
    localparam state_t ST_WRITE_BACK  = 2'd2;
    localparam state_t ST_ALLOCATE    = 2'd3;

    // Select one 32-bit word out of a line
    function automatic logic [WORD_W-1:0] line_word(input cache_data_type line,
                                                    input logic [1:0]     sel);
        return line[sel*WORD_W +: WORD_W];
    endfunction

    // Replace one 32-bit word of a line
    function automatic cache_data_type line_merge(input cache_data_type    line,
                                                  input logic [1:0]        sel,
                                                  input logic [WORD_W-1:0] word);
        cache_data_type r;
        r = line;
        r[sel*WORD_W +: WORD_W] = word;
        return r;
    endfunction

endpackage

// File: rtl/dm_cache_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// dm_cache_ctrl_fsm
// Controller for a direct-mapped, write-back, write-allocate cache placed
// between a CPU and main memory. It drives a 1024x128b data array and a
// 1024x20b tag array (both with combinational read ports) and issues
// line-sized write-back / allocate requests to memory.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   cpu_req_valid/rw/addr/data   CPU request, held until cpu_res_ready
//   cpu_res_data, cpu_res_ready  read data and one-cycle completion pulse
//   mem_req_valid/rw/addr/data   registered line request to memory
//   mem_data, mem_ready          memory fill line and completion pulse
//   tag_req_index/we, tag_write  tag array control, tag_read is its output
//   data_req_index/we, data_write data array control, data_read its output
// ----------------------------------------------------------------------------
module dm_cache_ctrl_fsm
    import cache_def_pkg::*;
(
    input  logic                clk,
    input  logic                rst,

    input  logic                cpu_req_valid,
    input  logic                cpu_req_rw,
    input  logic [ADDR_W-1:0]   cpu_req_addr,
    input  logic [WORD_W-1:0]   cpu_req_data,
    output logic [WORD_W-1:0]   cpu_res_data,
    output logic                cpu_res_ready,

    output logic                mem_req_valid,
    output logic                mem_req_rw,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [LINE_W-1:0]   mem_req_data,
    input  logic [LINE_W-1:0]   mem_data,
    input  logic                mem_ready,

    output logic [INDEX_W-1:0]  tag_req_index,
    output logic                tag_req_we,
    output logic [TAG_W+1:0]    tag_write,
    input  logic [TAG_W+1:0]    tag_read,

    output logic [INDEX_W-1:0]  data_req_index,
    output logic                data_req_we,
    output logic [LINE_W-1:0]   data_write,
    input  logic [LINE_W-1:0]   data_read
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q,       state_d;
    logic                req_rw_q,      req_rw_d;
    logic [TAG_W-1:0]    req_tag_q,     req_tag_d;
    logic [INDEX_W-1:0]  req_index_q,   req_index_d;
    logic [1:0]          req_word_q,    req_word_d;
    logic [WORD_W-1:0]   req_data_q,    req_data_d;
    mem_req_type         mem_req_q,     mem_req_d;

    // Byte offset is never used by a word-granular cache
    logic [1:0]          unused_byte_bits;
    assign unused_byte_bits = cpu_req_addr[1:0];

    cache_tag_type       tag_rd;
    cache_tag_type       tag_wr;
    cache_req_type       tag_req;
    cache_req_type       data_req;
    cpu_result_type      cpu_res;
    mem_data_type        mem_in;
    logic                hit;
    logic [ADDR_W-1:0]   req_line_addr;

    assign tag_rd        = tag_read;
    assign mem_in        = {mem_data, mem_ready};
    assign hit           = tag_rd.valid && (tag_rd.tag == req_tag_q);
    assign req_line_addr = {req_tag_q, req_index_q, 4'h0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_rw_q    <= 1'b0;
            req_tag_q   <= '0;
            req_index_q <= '0;
            req_word_q  <= '0;
            req_data_q  <= '0;
            mem_req_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_rw_q    <= req_rw_d;
            req_tag_q   <= req_tag_d;
            req_index_q <= req_index_d;
            req_word_q  <= req_word_d;
            req_data_q  <= req_data_d;
            mem_req_q   <= mem_req_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        req_rw_d      = req_rw_q;
        req_tag_d     = req_tag_q;
        req_index_d   = req_index_q;
        req_word_d    = req_word_q;
        req_data_d    = req_data_q;
        mem_req_d     = mem_req_q;
        tag_wr        = '0;
        tag_req.we    = 1'b0;
        data_req.we   = 1'b0;
        data_write    = '0;
        cpu_res.data  = '0;
        cpu_res.ready = 1'b0;

        // In IDLE the arrays are looked up with the incoming address so
        // that tag/data are already valid when COMPARE_TAG is entered.
        if (state_q == ST_IDLE) begin
            tag_req.index = cpu_req_addr[INDEX_MSB:INDEX_LSB];
        end else begin
            tag_req.index = req_index_q;
        end
        data_req.index = tag_req.index;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req_valid) begin
                    req_rw_d    = cpu_req_rw;
                    req_tag_d   = cpu_req_addr[TAG_MSB:TAG_LSB];
                    req_index_d = cpu_req_addr[INDEX_MSB:INDEX_LSB];
                    req_word_d  = cpu_req_addr[WORD_MSB:WORD_LSB];
                    req_data_d  = cpu_req_data;
                    state_d     = ST_COMPARE_TAG;
                end
            end

            ST_COMPARE_TAG: begin
                if (hit) begin
                    if (req_rw_q) begin
                        data_write   = line_merge(data_read, req_word_q, req_data_q);
                        data_req.we  = 1'b1;
                        tag_wr       = '{valid: 1'b1, dirty: 1'b1, tag: req_tag_q};
                        tag_req.we   = 1'b1;
                    end else begin
                        cpu_res.data = line_word(data_read, req_word_q);
                    end
                    cpu_res.ready = 1'b1;
                    state_d       = ST_IDLE;
                end else if (tag_rd.valid && tag_rd.dirty) begin
                    // Victim is dirty: evict it before fetching the new line
                    mem_req_d.valid = 1'b1;
                    mem_req_d.rw    = 1'b1;
                    mem_req_d.addr  = {tag_rd.tag, req_index_q, 4'h0};
                    mem_req_d.data  = data_read;
                    state_d         = ST_WRITE_BACK;
                end else begin
                    mem_req_d.valid = 1'b1;
                    mem_req_d.rw    = 1'b0;
                    mem_req_d.addr  = req_line_addr;
                    mem_req_d.data  = '0;
                    state_d         = ST_ALLOCATE;
                end
            end

            ST_WRITE_BACK: begin
                if (mem_in.ready) begin
                    // Chain straight into the line read for the request
                    mem_req_d.valid = 1'b1;
                    mem_req_d.rw    = 1'b0;
                    mem_req_d.addr  = req_line_addr;
                    mem_req_d.data  = '0;
                    state_d         = ST_ALLOCATE;
                end
            end

            ST_ALLOCATE: begin
                if (mem_in.ready) begin
                    data_write  = mem_in.data;
                    data_req.we = 1'b1;
                    tag_wr      = '{valid: 1'b1, dirty: 1'b0, tag: req_tag_q};
                    tag_req.we  = 1'b1;
                    mem_req_d   = '0;
                    // Re-lookup hits next cycle; writes merge there
                    state_d     = ST_COMPARE_TAG;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A reset cycle must never commit anything to the arrays or the CPU
        if (rst) begin
            tag_req.we    = 1'b0;
            data_req.we   = 1'b0;
            cpu_res.ready = 1'b0;
            cpu_res.data  = '0;
        end
    end

    assign tag_req_index  = tag_req.index;
    assign tag_req_we     = tag_req.we;
    assign tag_write      = tag_wr;
    assign data_req_index = data_req.index;
    assign data_req_we    = data_req.we;
    assign cpu_res_data   = cpu_res.data;
    assign cpu_res_ready  = cpu_res.ready;
    assign mem_req_valid  = mem_req_q.valid;
    assign mem_req_rw     = mem_req_q.rw;
    assign mem_req_addr   = mem_req_q.addr;
    assign mem_req_data   = mem_req_q.data;

endmodule

// File: tb/tb_dm_cache_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tb_dm_cache_ctrl_fsm
// Drives CPU transactions from a vector table against the cache controller,
// with behavioural tag/data arrays and a main-memory responder. Expected CPU
// responses and memory requests are queued when stimulus is driven and
// compared when the DUT produces them.
// ----------------------------------------------------------------------------
module tb_dm_cache_ctrl_fsm;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req_valid, cpu_req_rw;
    logic [31:0]  cpu_req_addr, cpu_req_data, cpu_res_data;
    logic         cpu_res_ready;
    logic         mem_req_valid, mem_req_rw;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_data, mem_data;
    logic         mem_ready;
    logic [9:0]   tag_req_index, data_req_index;
    logic         tag_req_we, data_req_we;
    logic [19:0]  tag_write, tag_read;
    logic [127:0] data_write, data_read;

    always #5 clk = ~clk;

    dm_cache_ctrl_fsm dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw),
        .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
        .cpu_res_data(cpu_res_data), .cpu_res_ready(cpu_res_ready),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_data(mem_data), .mem_ready(mem_ready),
        .tag_req_index(tag_req_index), .tag_req_we(tag_req_we),
        .tag_write(tag_write), .tag_read(tag_read),
        .data_req_index(data_req_index), .data_req_we(data_req_we),
        .data_write(data_write), .data_read(data_read)
    );

    // Behavioural arrays with combinational read
    logic [19:0]  tag_mem  [1024];
    logic [127:0] data_mem [1024];
    assign tag_read  = tag_mem[tag_req_index];
    assign data_read = data_mem[data_req_index];
    always @(posedge clk) begin
        if (tag_req_we)  tag_mem[tag_req_index]   <= tag_write;
        if (data_req_we) data_mem[data_req_index] <= data_write;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Main memory: unwritten lines hold words equal to their own address
    logic [127:0] mem_model [logic [31:0]];
    function automatic logic [127:0] get_line(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a + 32'd12, a + 32'd8, a + 32'd4, a};
    endfunction

    typedef struct {
        bit           rw;
        logic [31:0]  addr;
        logic [127:0] data;
    } mem_exp_t;
    typedef struct {
        bit          rw;
        logic [31:0] rdata;
    } cpu_exp_t;
    mem_exp_t mem_q[$];
    cpu_exp_t cpu_q[$];

    bit mem_en  = 1'b1;
    int mem_lat = 3;

    // Memory responder: answers after mem_lat cycles, checks the request is
    // held stable while waiting and matches the next expected request.
    initial begin
        int           wait_cnt;
        logic [31:0]  cap_addr;
        logic         cap_rw;
        logic [127:0] cap_data;
        mem_exp_t     e;
        wait_cnt = 0;
        mem_ready = 1'b0;
        mem_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (!mem_en || rst) begin
                wait_cnt = 0;
            end else if (mem_ready) begin
                mem_ready = 1'b0;
                mem_data  = '0;
                wait_cnt  = 0;
            end else if (mem_req_valid) begin
                wait_cnt++;
                if (wait_cnt == 1) begin
                    cap_addr = mem_req_addr; cap_rw = mem_req_rw; cap_data = mem_req_data;
                end else begin
                    check("mem_req_stable", {mem_req_rw, mem_req_addr, mem_req_data[94:0]},
                          {cap_rw, cap_addr, cap_data[94:0]});
                end
                if (wait_cnt >= mem_lat) begin
                    if (mem_q.size() == 0) begin
                        check("mem_req_unexpected", {mem_req_rw, mem_req_addr}, 33'h0);
                    end else begin
                        e = mem_q.pop_front();
                        check("mem_req_rw_addr", {mem_req_rw, mem_req_addr}, {e.rw, e.addr});
                        if (e.rw) check("mem_wb_data", mem_req_data, e.data);
                    end
                    if (mem_req_rw) mem_model[mem_req_addr] = mem_req_data;
                    else            mem_data = get_line(mem_req_addr);
                    mem_ready = 1'b1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // CPU response monitor
    bit prev_rdy = 1'b0;
    always @(negedge clk) begin
        cpu_exp_t c;
        if (cpu_res_ready) begin
            check("res_not_back_to_back", {127'd0, prev_rdy}, 128'd0);
            if (cpu_q.size() == 0) begin
                check("res_unexpected", {127'd0, cpu_res_ready}, 128'd0);
            end else begin
                c = cpu_q.pop_front();
                if (!c.rw) check("cpu_res_data", {96'd0, cpu_res_data}, {96'd0, c.rdata});
            end
        end
        prev_rdy = cpu_res_ready;
    end

    typedef struct {
        bit           rw;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [31:0]  exp_rdata;
        bit           exp_hit;
        bit           exp_wb;
        logic [31:0]  wb_addr;
        logic [127:0] wb_data;
        logic [19:0]  exp_tag;
        logic [127:0] exp_line;
    } vec_t;
    vec_t vec [10];

    task automatic do_req(input int vi);
        vec_t     v;
        cpu_exp_t c;
        mem_exp_t m;
        int       lat;
        bit       got, saw_mem;
        v = vec[vi];
        @(posedge clk); #1;
        if (v.exp_wb) begin
            m.rw = 1'b1; m.addr = v.wb_addr; m.data = v.wb_data; mem_q.push_back(m);
        end
        if (!v.exp_hit) begin
            m.rw = 1'b0; m.addr = {v.addr[31:4], 4'h0}; m.data = '0; mem_q.push_back(m);
        end
        c.rw = v.rw; c.rdata = v.exp_rdata; cpu_q.push_back(c);
        cpu_req_valid = 1'b1; cpu_req_rw = v.rw; cpu_req_addr = v.addr; cpu_req_data = v.wdata;
        lat = 0; got = 1'b0; saw_mem = 1'b0;
        while (!got && lat < 200) begin
            @(posedge clk); #2;
            lat++;
            if (mem_req_valid) saw_mem = 1'b1;
            if (cpu_res_ready) got = 1'b1;
        end
        check($sformatf("v%0d_completed", vi), {127'd0, got}, 128'd1);
        check($sformatf("v%0d_mem_used", vi), {127'd0, saw_mem}, {127'd0, !v.exp_hit});
        if (v.exp_hit) check($sformatf("v%0d_hit_latency", vi), lat, 1);
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
        check($sformatf("v%0d_tag_entry", vi), tag_mem[v.addr[13:4]], v.exp_tag);
        check($sformatf("v%0d_data_line", vi), data_mem[v.addr[13:4]], v.exp_line);
        $display("txn %0d: %s addr=%h wdata=%h latency=%0d", vi, v.rw ? "WR" : "RD",
                 v.addr, v.wdata, lat);
    endtask

    localparam logic [127:0] L1000   = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    localparam logic [127:0] L1000W  = {32'h4444_4444, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
    localparam logic [127:0] L41000  = {32'h0004_100C, 32'h0004_1008, 32'h0004_1004, 32'h0004_1000};
    localparam logic [127:0] L41000W = {32'h0BAD_F00D, 32'h0004_1008, 32'h0004_1004, 32'h0004_1000};
    localparam logic [127:0] L2010   = {32'h0000_201C, 32'h0000_2018, 32'h0000_2014, 32'h0000_2010};
    localparam logic [127:0] L81000  = {32'h0008_100C, 32'h0008_1008, 32'h0008_1004, 32'h0008_1000};
    localparam logic [127:0] L3000   = {32'h0000_300C, 32'h0000_3008, 32'h0000_3004, 32'h0000_3000};

    initial begin
        int ok;
        //           rw    addr           wdata          rdata          hit  wb  wb_addr        wb_data  tag        line
        vec[0] = '{1'b0, 32'h0000_1004, 32'h0,         32'h2222_2222, 1'b0, 1'b0, 32'h0,         '0,      20'h80000, L1000};
        vec[1] = '{1'b0, 32'h0000_1004, 32'h0,         32'h2222_2222, 1'b1, 1'b0, 32'h0,         '0,      20'h80000, L1000};
        vec[2] = '{1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 32'h0,         1'b1, 1'b0, 32'h0,         '0,      20'hC0000, L1000W};
        vec[3] = '{1'b0, 32'h0004_1000, 32'h0,         32'h0004_1000, 1'b0, 1'b1, 32'h0000_1000, L1000W, 20'h80010, L41000};
        vec[4] = '{1'b0, 32'h0000_1008, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,         '0,      20'h80000, L1000W};
        vec[5] = '{1'b1, 32'h0004_100C, 32'h0BAD_F00D, 32'h0,         1'b0, 1'b0, 32'h0,         '0,      20'hC0010, L41000W};
        vec[6] = '{1'b0, 32'h0004_100C, 32'h0,         32'h0BAD_F00D, 1'b1, 1'b0, 32'h0,         '0,      20'hC0010, L41000W};
        vec[7] = '{1'b0, 32'h0000_2010, 32'h0,         32'h0000_2010, 1'b0, 1'b0, 32'h0,         '0,      20'h80000, L2010};
        vec[8] = '{1'b0, 32'h0008_1004, 32'h0,         32'h0008_1004, 1'b0, 1'b1, 32'h0004_1000, L41000W, 20'h80020, L81000};
        vec[9] = '{1'b0, 32'h0000_3000, 32'h0,         32'h0000_3000, 1'b0, 1'b0, 32'h0,         '0,      20'h80000, L3000};

        for (int i = 0; i < 1024; i++) begin
            tag_mem[i] = '0; data_mem[i] = '0;
        end
        mem_model[32'h0000_1000] = L1000;
        rst = 1'b1;
        cpu_req_valid = 1'b0; cpu_req_rw = 1'b0; cpu_req_addr = '0; cpu_req_data = '0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs",
              {cpu_res_ready, mem_req_valid, mem_req_rw, data_req_we, tag_req_we, cpu_res_data, mem_req_addr},
              '0);
        check("reset_mem_req_data", mem_req_data, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) do_req(i);

        // Memory stalls in ALLOCATE: request held, nothing completes
        mem_en = 1'b0;
        @(posedge clk); #1;
        cpu_req_valid = 1'b1; cpu_req_rw = 1'b0; cpu_req_addr = 32'h0000_3000; cpu_req_data = '0;
        ok = 0;
        for (int k = 0; k < 10 && ok == 0; k++) begin
            @(posedge clk); #2;
            if (mem_req_valid) ok = 1;
        end
        check("stall_req_issued", {mem_req_valid, mem_req_rw, mem_req_addr}, {1'b1, 1'b0, 32'h0000_3000});
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #2;
            check($sformatf("stall_cycle_%0d", k),
                  {mem_req_valid, mem_req_rw, mem_req_addr, cpu_res_ready, data_req_we, tag_req_we},
                  {1'b1, 1'b0, 32'h0000_3000, 3'b000});
        end
        $display("txn stall: RD addr=00003000 held 10 cycles without mem_ready");

        // Reset during the ALLOCATE wait, then a late mem_ready
        @(posedge clk); #1;
        rst = 1'b1; cpu_req_valid = 1'b0;
        #1;
        check("rst_cycle_no_write", {data_req_we, tag_req_we, cpu_res_ready}, 3'b000);
        @(posedge clk); #2;
        check("rst_abandons_req", {mem_req_valid, data_req_we, tag_req_we, cpu_res_ready}, 4'b0000);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_data = {4{32'hBADD_A7A0}}; mem_ready = 1'b1;
        #1;
        check("late_ready_ignored", {data_req_we, tag_req_we, cpu_res_ready, mem_req_valid}, 4'b0000);
        @(posedge clk); #1;
        mem_ready = 1'b0; mem_data = '0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #2;
            check($sformatf("post_rst_idle_%0d", k),
                  {mem_req_valid, data_req_we, tag_req_we, cpu_res_ready}, 4'b0000);
        end
        check("post_rst_tag_untouched", tag_mem[10'h300], 20'h0);
        check("post_rst_data_untouched", data_mem[10'h300], '0);
        $display("txn reset: rst during ALLOCATE wait, late mem_ready ignored");

        // CPU re-issues after the reset
        mem_en = 1'b1;
        do_req(9);

        repeat (3) @(posedge clk);
        check("cpu_queue_drained", cpu_q.size(), 0);
        check("mem_queue_drained", mem_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
